alu_accum_pipe: RTL and testbench



---
 rtl/alu_accum_pipe.sv | 104 ++++++++++
 tb/tb_alu_accum_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_accum_pipe.sv
// Pipelined unsigned add/subtract/accumulate unit for frame-buffer address arithmetic.
// The result register dout doubles as the accumulator and is fed straight back into the compute stage.
module alu_accum_pipe #(
    parameter int A_WIDTH   = 21,
    parameter int B_WIDTH   = 5,
    parameter int OUT_WIDTH = 22,
    parameter int PIPE_IN   = 0,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic                 accload,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 carry,
    output logic                 ovf_sticky
);

    localparam int CW = OUT_WIDTH + 1;

    logic               s_valid;
    logic               s_accload;
    logic [1:0]         s_mode;
    logic [A_WIDTH-1:0] s_a;
    logic [B_WIDTH-1:0] s_b;

    generate
        if (PIPE_IN != 0) begin : g_in_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    s_valid   <= 1'b0;
                    s_accload <= 1'b0;
                    s_mode    <= '0;
                    s_a       <= '0;
                    s_b       <= '0;
                end else if (ce) begin
                    s_valid   <= in_valid;
                    s_accload <= accload;
                    s_mode    <= mode;
                    s_a       <= a;
                    s_b       <= b;
                end
            end
        end else begin : g_in_comb
            assign s_valid   = in_valid;
            assign s_accload = accload;
            assign s_mode    = mode;
            assign s_a       = a;
            assign s_b       = b;
        end
    endgenerate

    logic [CW-1:0]        op_a;
    logic [CW-1:0]        op_b;
    logic [CW-1:0]        sum;
    logic [CW-1:0]        diff;
    logic                 cy;
    logic [OUT_WIDTH-1:0] res;

    // Both operands are below 2^OUT_WIDTH, so bit OUT_WIDTH of the difference is exactly the borrow.
    always_comb begin
        op_a = s_mode[1] ? {1'b0, dout} : CW'(s_a);
        op_b = CW'(s_b);
        sum  = op_a + op_b;
        diff = op_a - op_b;
        if (s_mode[0]) begin
            cy  = diff[OUT_WIDTH];
            res = diff[OUT_WIDTH-1:0];
            if (SATURATE != 0 && cy) res = '0;
        end else begin
            cy  = sum[OUT_WIDTH];
            res = sum[OUT_WIDTH-1:0];
            if (SATURATE != 0 && cy) res = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            dout       <= '0;
            carry      <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (ce) begin
            out_valid <= s_valid;
            if (s_valid) begin
                if (s_accload) begin
                    dout       <= OUT_WIDTH'(s_a);
                    carry      <= 1'b0;
                    ovf_sticky <= 1'b0;
                end else begin
                    dout       <= res;
                    carry      <= cy;
                    ovf_sticky <= ovf_sticky | cy;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_accum_pipe.sv
// Bench for alu_accum_pipe: wrapping, saturating and input-registered builds driven in lockstep.
module tb_alu_accum_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [1:0]  mode;
    logic        accload;
    logic [21:0] a;
    logic [4:0]  b;

    logic        w_valid, s_valid, p_valid;
    logic [21:0] w_dout, s_dout, p_dout;
    logic        w_carry, s_carry, p_carry;
    logic        w_ovf, s_ovf, p_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_accum_pipe #(.A_WIDTH(22), .B_WIDTH(5), .OUT_WIDTH(22), .PIPE_IN(0), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .mode(mode), .accload(accload),
        .a(a), .b(b), .out_valid(w_valid), .dout(w_dout), .carry(w_carry), .ovf_sticky(w_ovf));

    alu_accum_pipe #(.A_WIDTH(22), .B_WIDTH(5), .OUT_WIDTH(22), .PIPE_IN(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .mode(mode), .accload(accload),
        .a(a), .b(b), .out_valid(s_valid), .dout(s_dout), .carry(s_carry), .ovf_sticky(s_ovf));

    alu_accum_pipe #(.A_WIDTH(22), .B_WIDTH(5), .OUT_WIDTH(22), .PIPE_IN(1), .SATURATE(0)) u_pipe (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .mode(mode), .accload(accload),
        .a(a), .b(b), .out_valid(p_valid), .dout(p_dout), .carry(p_carry), .ovf_sticky(p_ovf));

    typedef struct {
        logic        vld;
        logic [1:0]  md;
        logic        ld;
        logic [21:0] av;
        logic [4:0]  bv;
        logic        ev;
        logic [21:0] ed;
        logic        ec;
        logic        eo;
        logic [21:0] eds;
    } vec_t;

    localparam int N = 17;
    vec_t vec [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic v, input logic [1:0] m,
                       input logic l, input logic [21:0] av, input logic [4:0] bv);
        @(negedge clk);
        reset = r; ce = e; in_valid = v; mode = m; accload = l; a = av; b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic v, input logic [21:0] d, input logic c, input logic o);
        chk({tag, " wrap valid"}, 32'(w_valid), 32'(v));
        chk({tag, " wrap dout"}, 32'(w_dout), 32'(d));
        chk({tag, " wrap carry"}, 32'(w_carry), 32'(c));
        chk({tag, " wrap ovf"}, 32'(w_ovf), 32'(o));
    endtask

    task automatic chk_p(input string tag, input logic v, input logic [21:0] d, input logic c, input logic o);
        chk({tag, " pipe valid"}, 32'(p_valid), 32'(v));
        chk({tag, " pipe dout"}, 32'(p_dout), 32'(d));
        chk({tag, " pipe carry"}, 32'(p_carry), 32'(c));
        chk({tag, " pipe ovf"}, 32'(p_ovf), 32'(o));
    endtask

    initial begin
        //           vld  md    ld  a          b      ev  wrap dout  c  o   sat dout
        vec[0]  = '{1'b1, 2'b00, 1'b0, 22'd2097151, 5'd31, 1'b1, 22'd2097182, 1'b0, 1'b0, 22'd2097182};
        vec[1]  = '{1'b0, 2'b00, 1'b0, 22'd0,       5'd0,  1'b0, 22'd2097182, 1'b0, 1'b0, 22'd2097182};
        vec[2]  = '{1'b1, 2'b00, 1'b1, 22'd4194300, 5'd0,  1'b1, 22'd4194300, 1'b0, 1'b0, 22'd4194300};
        vec[3]  = '{1'b1, 2'b10, 1'b0, 22'd0,       5'd3,  1'b1, 22'd4194303, 1'b0, 1'b0, 22'd4194303};
        vec[4]  = '{1'b1, 2'b10, 1'b0, 22'd0,       5'd3,  1'b1, 22'd2,       1'b1, 1'b1, 22'd4194303};
        vec[5]  = '{1'b1, 2'b01, 1'b0, 22'd3,       5'd10, 1'b1, 22'd4194297, 1'b1, 1'b1, 22'd0};
        vec[6]  = '{1'b1, 2'b11, 1'b1, 22'd0,       5'd9,  1'b1, 22'd0,       1'b0, 1'b0, 22'd0};
        vec[7]  = '{1'b1, 2'b11, 1'b0, 22'd0,       5'd1,  1'b1, 22'd4194303, 1'b1, 1'b1, 22'd0};
        vec[8]  = '{1'b1, 2'b00, 1'b1, 22'd100,     5'd0,  1'b1, 22'd100,     1'b0, 1'b0, 22'd100};
        vec[9]  = '{1'b1, 2'b10, 1'b0, 22'd0,       5'd1,  1'b1, 22'd101,     1'b0, 1'b0, 22'd101};
        vec[10] = '{1'b1, 2'b10, 1'b0, 22'd0,       5'd1,  1'b1, 22'd102,     1'b0, 1'b0, 22'd102};
        vec[11] = '{1'b1, 2'b10, 1'b0, 22'd0,       5'd1,  1'b1, 22'd103,     1'b0, 1'b0, 22'd103};
        vec[12] = '{1'b1, 2'b11, 1'b0, 22'd0,       5'd4,  1'b1, 22'd99,      1'b0, 1'b0, 22'd99};
        vec[13] = '{1'b1, 2'b00, 1'b0, 22'd5,       5'd31, 1'b1, 22'd36,      1'b0, 1'b0, 22'd36};
        vec[14] = '{1'b1, 2'b01, 1'b0, 22'd31,      5'd31, 1'b1, 22'd0,       1'b0, 1'b0, 22'd0};
        vec[15] = '{1'b0, 2'b10, 1'b0, 22'd0,       5'd7,  1'b0, 22'd0,       1'b0, 1'b0, 22'd0};
        vec[16] = '{1'b0, 2'b00, 1'b1, 22'd55,      5'd0,  1'b0, 22'd0,       1'b0, 1'b0, 22'd0};

        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; mode = 2'b00; accload = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_w("reset", 1'b0, 22'd0, 1'b0, 1'b0);
        chk_p("reset", 1'b0, 22'd0, 1'b0, 1'b0);

        // Pipe build must reproduce the wrap build's table one cycle later.
        for (int i = 0; i <= N; i++) begin
            if (i < N)
                cyc(1'b0, 1'b1, vec[i].vld, vec[i].md, vec[i].ld, vec[i].av, vec[i].bv);
            else
                cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 22'd0, 5'd0);
            if (i < N) begin
                chk_w($sformatf("v%0d", i), vec[i].ev, vec[i].ed, vec[i].ec, vec[i].eo);
                chk($sformatf("v%0d sat dout", i), 32'(s_dout), 32'(vec[i].eds));
                chk($sformatf("v%0d sat carry", i), 32'(s_carry), 32'(vec[i].ec));
                chk($sformatf("v%0d sat ovf", i), 32'(s_ovf), 32'(vec[i].eo));
            end
            if (i == 0)
                chk_p("v0", 1'b0, 22'd0, 1'b0, 1'b0);
            else
                chk_p($sformatf("v%0d", i - 1), vec[i-1].ev, vec[i-1].ed, vec[i-1].ec, vec[i-1].eo);
        end

        // Reset wins over ce=0.
        cyc(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 22'd9, 5'd1);
        chk_w("pre-rst", 1'b1, 22'd10, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 22'd0, 5'd0);
        chk_w("rst ce0", 1'b0, 22'd0, 1'b0, 1'b0);
        chk_p("rst ce0", 1'b0, 22'd0, 1'b0, 1'b0);

        // Clock-enable freeze with an op held in the pipe input stage.
        cyc(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 22'd100, 5'd0);
        chk_w("ce e1", 1'b1, 22'd100, 1'b0, 1'b0);
        chk_p("ce e1", 1'b0, 22'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 22'd0, 5'd1);
        chk_w("ce e2", 1'b1, 22'd101, 1'b0, 1'b0);
        chk_p("ce e2", 1'b1, 22'd100, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 22'd0, 5'd9);
            chk_w($sformatf("ce hold%0d", k), 1'b1, 22'd101, 1'b0, 1'b0);
            chk_p($sformatf("ce hold%0d", k), 1'b1, 22'd100, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 22'd0, 5'd0);
        chk_w("ce e6", 1'b0, 22'd101, 1'b0, 1'b0);
        chk_p("ce e6", 1'b1, 22'd101, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 22'd0, 5'd0);
        chk_p("ce e7", 1'b0, 22'd101, 1'b0, 1'b0);

        // Reset pulse between accumulate ops drops the in-flight op and clears acc.
        cyc(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 22'd50, 5'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 22'd0, 5'd2);
        chk_p("rst mid e2", 1'b1, 22'd50, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 22'd0, 5'd0);
        chk_p("rst mid e3", 1'b0, 22'd0, 1'b0, 1'b0);
        chk_w("rst mid e3", 1'b0, 22'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 22'd0, 5'd7);
        chk_p("rst mid e4", 1'b0, 22'd0, 1'b0, 1'b0);
        chk_w("rst mid e4", 1'b1, 22'd7, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 22'd0, 5'd0);
        chk_p("rst mid e5", 1'b1, 22'd7, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
